// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and lane helpers for the multicycle-MIPS memory access controller.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  // Reserved size 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(logic [1:0] off, logic [1:0] size);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(logic [1:0] off, logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(logic [31:0] wdata, logic [1:0] size);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(logic [31:0] old, logic [31:0] wdata,
                                              logic [1:0] off, logic [1:0] size);
    logic [31:0] rep;
    logic [3:0]  mask;
    logic [31:0] res;
    rep  = lane_replicate(wdata, size);
    mask = lane_mask(off, size);
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? rep[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a loaded word and sign- or zero-extends it.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {addr_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller driving a single-port word RAM.
// Define MEMCTL_BYTE_STROBE_EN for lane write enables (mem_be) instead of read-modify-write.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
`ifdef MEMCTL_BYTE_STROBE_EN
  output logic [3:0]        mem_be,
`endif
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              mis_q, mis_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       ext_data;
  logic              req_mis;
  logic              req_subword;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  load_extend u_load_extend (
    .word_i     (mem_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    mis_d       = mis_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    req_mis     = is_misaligned(req_addr[1:0], req_size);
    req_subword = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W+1:0];
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          mis_d   = req_mis;
          rdata_d = '0;
          cnt_d   = '0;
`ifdef MEMCTL_BYTE_STROBE_EN
          wdata_d = lane_replicate(req_wdata, req_size);
`else
          wdata_d = req_wdata;
`endif
          if (req_mis) begin
            state_d = StResp;
          end else if (!req_we) begin
            state_d = StRead;
          end else if (req_subword) begin
`ifdef MEMCTL_BYTE_STROBE_EN
            state_d = StWrite;
`else
            state_d = StRead;
`endif
          end else begin
            state_d = StWrite;
          end
        end
      end
      StRead: begin
        if (cnt_q == CntLast) begin
          if (we_q) begin
            wdata_d = merge_lanes(mem_rdata, wdata_q, addr_q[1:0], size_q);
            state_d = StWrite;
          end else begin
            rdata_d = ext_data;
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: state_d = StResp;
      StResp: begin
        rdata_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready       = (state_q == StIdle);
  assign resp_valid      = (state_q == StResp);
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_rdata      = rdata_q;
  assign mem_addr        = addr_q[ADDR_W+1:2];
  assign mem_we          = (state_q == StWrite);
  assign mem_wdata       = mem_we ? wdata_q : '0;
`ifdef MEMCTL_BYTE_STROBE_EN
  assign mem_be          = mem_we ? lane_mask(addr_q[1:0], size_q) : 4'b0000;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-level memory model with latency rules.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LAT    = 3;
  localparam int unsigned NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = '0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = '0;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef MEMCTL_BYTE_STROBE_EN
  logic [3:0]        mem_be;
`endif

  mem_access_ctrl #(
    .ADDR_W  (ADDR_W),
    .MEM_LAT (LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
`ifdef MEMCTL_BYTE_STROBE_EN
    .mem_be          (mem_be),
`endif
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: data valid LAT-1 cycles after the address first appears.
  logic [31:0]       ram [NWORDS];
  logic [31:0]       ref_mem [NWORDS];
  logic [ADDR_W-1:0] pipe [4];
  logic [ADDR_W-1:0] rd_idx;
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_idx = '0;
  logic [31:0]       poke_val = '0;

  always @(posedge clk) begin
    pipe[0] <= mem_addr;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    if (poke_en) ram[poke_idx] <= poke_val;
    if (mem_we) begin
`ifdef MEMCTL_BYTE_STROBE_EN
      for (int l = 0; l < 4; l++) if (mem_be[l]) ram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
`else
      ram[mem_addr] <= mem_wdata;
`endif
    end
  end

  always_comb begin
    rd_idx = (LAT <= 1) ? mem_addr : pipe[(LAT + 2) % 4];
  end
  assign mem_rdata = ram[rd_idx];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    poke_idx = idx[ADDR_W-1:0];
    poke_val = v;
    poke_en  = 1'b1;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  function automatic logic [31:0] model_load(logic [31:0] w, int off, int sz, logic uns);
    longint unsigned v;
    v = longint'(w) >> (8 * off);
    if (sz == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic do_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, output logic [31:0] got);
    int   idx, off, sz, nbytes, exp_cyc, resp_cyc, we_cnt, w;
    logic mis, mis_seen;
    logic [31:0] exp_rd, word;
    idx    = int'(addr[ADDR_W+1:2]);
    off    = int'(addr[1:0]);
    sz     = (size == 2'b11) ? 2 : int'(size);
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis    = (off % nbytes) != 0;
    if (mis) exp_cyc = 1;
    else if (!we) exp_cyc = LAT + 1;
    else if (sz == 2) exp_cyc = 2;
`ifdef MEMCTL_BYTE_STROBE_EN
    else exp_cyc = 2;
`else
    else exp_cyc = LAT + 2;
`endif
    exp_rd = (we || mis) ? 32'h0 : model_load(ref_mem[idx], off, sz, uns);

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_idle", {31'h0, req_ready}, 32'h1);
    req_addr = addr; req_we = we; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;

    resp_cyc = 0; we_cnt = 0; got = '0; mis_seen = 1'b0;
    for (int c = 1; c <= int'(LAT) + 4 && resp_cyc == 0; c++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (c == 1) begin
        chk("busy", {31'h0, req_ready}, 32'h0);
        chk("mem_addr", {24'h0, mem_addr}, idx);
      end
      if (resp_valid) begin
        resp_cyc = c;
        got      = resp_rdata;
        mis_seen = resp_misaligned;
      end
    end
    chk("resp_cycle", resp_cyc, exp_cyc);
    chk("misaligned", {31'h0, mis_seen}, {31'h0, mis});
    chk("rdata", got, exp_rd);
    chk("we_count", we_cnt, (we && !mis) ? 1 : 0);

    if (we && !mis) begin
      word = ref_mem[idx];
      for (int k = 0; k < nbytes; k++) word[8*(off+k) +: 8] = wdata[8*k +: 8];
      ref_mem[idx] = word;
    end
    chk("ram_word", ram[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] g;
    logic [31:0] a;
    int          bad;

    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    for (int i = 0; i < int'(NWORDS); i++) poke(i, $urandom);
    @(negedge clk);
    reset_n = 1'b1;

    poke(4, 32'hDEAD_BEEF);
    do_req(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, g);
    chk("lw_0x10", g, 32'hDEAD_BEEF);

    poke(4, 32'h80FF_0000);
    do_req(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, g);
    chk("lb_0x13", g, 32'hFFFF_FF80);
    do_req(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, g);
    chk("lbu_0x13", g, 32'h0000_0080);

    poke(4, 32'h1122_3344);
    do_req(32'h11, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, g);
    chk("sb_merge", ram[4], 32'h1122_AB44);

    do_req(32'h12, 1'b0, 2'b10, 1'b0, 32'h0, g);
    do_req(32'h03, 1'b1, 2'b01, 1'b0, 32'h1234_5678, g);
    chk("sh_mis_ram", ram[0], ref_mem[0]);

    poke(63, 32'hA1B2_C3D4);
    do_req(32'd253, 1'b0, 2'b00, 1'b0, 32'h0, g);
    chk("lb_253", g, 32'hFFFF_FFC3);
    do_req(32'd254, 1'b0, 2'b00, 1'b0, 32'h0, g);
    chk("lb_254", g, 32'hFFFF_FFB2);
    do_req(32'd255, 1'b0, 2'b00, 1'b0, 32'h0, g);
    chk("lb_255", g, 32'hFFFF_FFA1);

    // Reset in the first cycle after accepting a sub-word store: the write must never land.
    poke(5, 32'h1122_3344);
    @(negedge clk);
    req_addr = 32'h14; req_we = 1'b1; req_size = 2'b00; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_resp", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_we", {31'h0, mem_we}, 32'h0);
    chk("mid_rst_addr", {24'h0, mem_addr}, 32'h0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_we || resp_valid) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_ram", ram[5], 32'h1122_3344);
    chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 63);
      do_req(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
